apb3_master_arbiter: RTL and testbench
======================================

Name: apb3_master_arbiter

Overview:
- APB3 (AMBA 3 rev B) requester-side controller that shares one APB3 slave port (e.g. a register-set slave) between N_REQ local requesters.
- Round-robin arbitration, registered capture of the winning request, IDLE/SETUP/ACCESS sequencing on the bus, response return to the granted requester.
- Sits between internal masters (CPU stub, DMA, test sequencer) and the APB3 register-set slave.

Parameters:
- N_REQ, 2: number of requesters, ≥2.
- N_BIT_DATA, 32: PWDATA/PRDATA width.
- N_BIT_ADDRESS, 4: PADDR width.
- TIMEOUT_CYCLES, 16: ACCESS-wait limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held with payload until its req_done.
- req_write  in  N_REQ  1=write, 0=read.
- req_addr  in  N_REQ*N_BIT_ADDRESS  packed addresses; requester i at slice i.
- req_wdata  in  N_REQ*N_BIT_DATA  packed write data.
- req_done  out  N_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  N_BIT_DATA  read data, valid while req_done≠0.
- rsp_err  out  1  error flag, valid while req_done≠0.
- PSEL, PENABLE, PWRITE  out  1  APB3 control.
- PADDR  out  N_BIT_ADDRESS  APB3 address.
- PWDATA  out  N_BIT_DATA  APB3 write data.
- PRDATA  in  N_BIT_DATA  APB3 read data.
- PREADY, PSLVERR  in  1  APB3 ready/error.

Behaviour:
- Reset (PRESET=1 at edge): state IDLE; all outputs 0; RR pointer 0 (requester 0 highest priority); timeout counter 0. Reset mid-transfer aborts silently, no req_done pulse.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: PSEL=0, PENABLE=0. If any req_valid: pick first set bit searching from pointer upward, wrapping at N_REQ; register grant index, req_write/addr/wdata of winner into PWRITE/PADDR/PWDATA; -> SETUP. Else stay.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle; -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PWRITE/PADDR/PWDATA stable. PREADY=0 -> stay. PREADY=1 -> capture PRDATA (reads; 0 for writes) into rsp_rdata, PSLVERR into rsp_err; -> DONE.
- DONE: PSEL=PENABLE=0; req_done[grant]=1 for this cycle only; pointer <= (grant+1) mod N_REQ; -> IDLE.
- rsp_rdata/rsp_err hold last value outside DONE; checked only during DONE.
- Latency: min 4 cycles from req_valid sampled in IDLE to req_done; each PREADY=0 cycle adds one.
- Requester drops req_valid at the edge after req_done; IDLE samples post-drop value, no double grant.
- Payload changes of a granted requester after IDLE capture are ignored.
- Non-granted requests wait; no starvation: each waits at most N_REQ-1 transfers.
- PADDR/PWDATA/PWRITE retain values in IDLE/DONE (no toggling when unselected).

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: counter increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES with PREADY still 0, abort: -> DONE, rsp_err=1, rsp_rdata=0. Counter clears on leaving ACCESS. PREADY=1 in the limit cycle completes normally.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err = captured PSLVERR only.

Test Plan:
- Reset: PRESET=1 mid-ACCESS, 2 cycles -> next cycle IDLE, PSEL=PENABLE=0, req_done=0, no done pulse; later request from 1 wins over 0 only if pointer rule says so (pointer=0 -> 0 wins).
- Single write: req0 write addr 0x3 data 0xDEADBEEF, PREADY=1 -> SETUP then ACCESS with PADDR=3, PWDATA=0xDEADBEEF, PWRITE=1; req_done=01 exactly 4 cycles after request, rsp_err=0.
- Read with wait states: req1 read addr 0x5, PREADY low 3 cycles then high with PRDATA=0x12345678 -> req_done=10 on 7th cycle, rsp_rdata=0x12345678.
- Round robin: req0 and req1 held continuously for 4 transfers -> grants 0,1,0,1; PSEL low for DONE+IDLE between transfers.
- Slave error: PSLVERR=1 with PREADY=1 on read of 0xA -> rsp_err=1 in DONE; next transfer rsp_err=0.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0; without macro PSEL stays 1 for 100 cycles.

Source files
------------

// File: rtl/apb3_master_arbiter_if.sv
// rtl/apb3_master_arbiter_if.sv - APB3 bus bundle between the arbitrating requester and the slave
interface apb3_master_arbiter_if #(
    parameter int N_BIT_DATA    = 32,
    parameter int N_BIT_ADDRESS = 4
);
    logic                     PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [N_BIT_ADDRESS-1:0] PADDR;
    logic [N_BIT_DATA-1:0]    PWDATA;
    logic [N_BIT_DATA-1:0]    PRDATA;
    logic                     PREADY;
    logic                     PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb3_master_arbiter.sv
// rtl/apb3_master_arbiter.sv - round-robin N_REQ-to-one APB3 requester; optional ACCESS timeout under APB_TIMEOUT_EN
module apb3_master_arbiter #(
    parameter int N_REQ          = 2,
    parameter int N_BIT_DATA     = 32,
    parameter int N_BIT_ADDRESS  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_write,
    input  logic [N_REQ*N_BIT_ADDRESS-1:0] req_addr,
    input  logic [N_REQ*N_BIT_DATA-1:0]    req_wdata,
    output logic [N_REQ-1:0]               req_done,
    output logic [N_BIT_DATA-1:0]          rsp_rdata,
    output logic                           rsp_err,
    apb3_master_arbiter_if.master          apb
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb3_master_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant;
    logic [IDX_W-1:0]         cand;
    logic [IDX_W-1:0]         win_idx;
    logic                     win_found;
    logic                     win_write;
    logic [N_BIT_ADDRESS-1:0] win_addr;
    logic [N_BIT_DATA-1:0]    win_wdata;
    logic                     tmo_hit;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    // The limit cycle itself still honours PREADY=1; abort only if the slave is still stalling.
    assign tmo_hit = !apb.PREADY && (int'(tmo_cnt) == TIMEOUT_CYCLES - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    // Search upward from the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_write = req_write[k];
                win_addr  = req_addr[k*N_BIT_ADDRESS +: N_BIT_ADDRESS];
                win_wdata = req_wdata[k*N_BIT_DATA +: N_BIT_DATA];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            req_done <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant      <= win_idx;
                        apb.PWRITE <= win_write;
                        apb.PADDR  <= win_addr;
                        apb.PWDATA <= win_wdata;
                        apb.PSEL   <= 1'b1;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb.PREADY || tmo_hit) begin
                        rsp_rdata       <= (apb.PWRITE || tmo_hit) ? '0 : apb.PRDATA;
                        rsp_err         <= apb.PREADY ? apb.PSLVERR : 1'b1;
                        apb.PSEL        <= 1'b0;
                        apb.PENABLE     <= 1'b0;
                        req_done[grant] <= 1'b1;
                        state           <= S_DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    if (apb.PREADY || tmo_hit) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    rr_ptr <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb3_master_arbiter.sv
// tb/tb_apb3_master_arbiter.sv - scoreboard bench for apb3_master_arbiter (N_REQ=2)
module tb_apb3_master_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    apb3_master_arbiter_if #(.N_BIT_DATA(32), .N_BIT_ADDRESS(4)) bus ();

    apb3_master_arbiter #(
        .N_REQ(2), .N_BIT_DATA(32), .N_BIT_ADDRESS(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb(bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    int          slv_wait  = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    logic        slv_stuck = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: programmable wait states, or stuck low.
    initial begin
        int wait_left;
        wait_left   = 0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && !bus.PENABLE) begin
                wait_left  = slv_wait;
                bus.PREADY = 1'b0;
            end else if (bus.PSEL && bus.PENABLE) begin
                if (slv_stuck || wait_left > 0) begin
                    bus.PREADY = 1'b0;
                    if (wait_left > 0) wait_left--;
                end else begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = slv_rdata;
                    bus.PSLVERR = slv_err;
                end
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end
        end
    end

    // Scoreboard: bus phase checked against queue head, completion pops it.
    initial begin
        forever begin
            @(negedge PCLK);
            #1;
            if (!PRESET && bus.PSEL && bus.PENABLE && bus.PREADY && exp_q.size() > 0) begin
                check("paddr", 64'(bus.PADDR), 64'(exp_q[0].addr));
                check("pwrite", 64'(bus.PWRITE), 64'(exp_q[0].write));
                if (exp_q[0].write) check("pwdata", 64'(bus.PWDATA), 64'(exp_q[0].wdata));
            end
            if (!PRESET && req_done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 64'(req_done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", 64'(req_done), 64'd1 << e.idx);
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("psel_in_done", 64'(bus.PSEL), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input int i, input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic er);
        exp_t x;
        x.idx = i; x.write = w; x.addr = a; x.wdata = d; x.rdata = rd; x.err = er;
        exp_q.push_back(x);
    endtask

    task automatic raise(input int i, input logic w, input logic [3:0] a, input logic [31:0] d);
        req_valid[i]        = 1'b1;
        req_write[i]        = w;
        req_addr[i*4 +: 4]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic wait_done(input int start, output int idx, output int cyc);
        cyc = start;
        idx = -1;
        while (cyc < 300) begin
            @(negedge PCLK);
            cyc++;
            if (req_done != 2'b00) begin
                idx = (req_done == 2'b01) ? 0 : (req_done == 2'b10) ? 1 : 9;
                break;
            end
        end
        if (idx < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_access(input string tag);
        int n;
        n = 0;
        while (!(bus.PSEL && bus.PENABLE) && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check(tag, 64'(bus.PSEL && bus.PENABLE), 64'd1);
    endtask

    // One isolated transfer; payload is scrambled after capture and must not leak onto the bus.
    task automatic run_one(input int i, input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input logic er, input int lat);
        int idx, cyc;
        push(i, w, a, d, rd, er);
        @(posedge PCLK); #1;
        raise(i, w, a, d);
        @(negedge PCLK);
        @(posedge PCLK); #1;
        raise(i, ~w, a ^ 4'hF, ~d);
        @(negedge PCLK);
        check("setup_psel", 64'(bus.PSEL), 64'd1);
        check("setup_penable", 64'(bus.PENABLE), 64'd0);
        wait_done(2, idx, cyc);
        check("latency", 64'(cyc), 64'(lat));
        @(posedge PCLK); #1;
        req_valid[i] = 1'b0;
        @(negedge PCLK);
        check("rdata_hold", 64'(rsp_rdata), 64'(rd));
        check("paddr_hold", 64'(bus.PADDR), 64'(a));
        check("psel_idle", 64'(bus.PSEL), 64'd0);
    endtask

    // Both requesters held continuously; pointer assumed 0 at entry so grants alternate 0,1,...
    task automatic rr_burst(input int per_req);
        int idx, cyc, cnt0, cnt1;
        cnt0 = 0; cnt1 = 0;
        for (int r = 0; r < per_req; r++) begin
            push(0, 1'b1, 4'(8 + r), 32'hA0A0_0000 + 32'(r), 32'h0, 1'b0);
            push(1, 1'b0, 4'(2 + r), 32'h0, slv_rdata, 1'b0);
        end
        @(posedge PCLK); #1;
        raise(0, 1'b1, 4'd8, 32'hA0A0_0000);
        raise(1, 1'b0, 4'd2, 32'h0);
        for (int k = 0; k < 2 * per_req; k++) begin
            wait_done(0, idx, cyc);
            if (idx < 0) break;
            @(posedge PCLK); #1;
            if (idx == 0) begin
                cnt0++;
                if (cnt0 == per_req) req_valid[0] = 1'b0;
                else raise(0, 1'b1, 4'(8 + cnt0), 32'hA0A0_0000 + 32'(cnt0));
            end else if (idx == 1) begin
                cnt1++;
                if (cnt1 == per_req) req_valid[1] = 1'b0;
                else raise(1, 1'b0, 4'(2 + cnt1), 32'h0);
            end
            @(negedge PCLK);
            check("rr_gap_psel", 64'(bus.PSEL), 64'd0);
        end
        req_valid = '0;
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_psel", 64'(bus.PSEL), 64'd0);
        check("rst_penable", 64'(bus.PENABLE), 64'd0);
        check("rst_req_done", 64'(req_done), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_paddr", 64'(bus.PADDR), 64'd0);
        check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        check("rst_pwrite", 64'(bus.PWRITE), 64'd0);

        run_one(0, 1'b1, 4'h3, 32'hDEADBEEF, 32'h0, 1'b0, 4);

        slv_wait = 3; slv_rdata = 32'h12345678;
        run_one(1, 1'b0, 4'h5, 32'h0, 32'h12345678, 1'b0, 7);

        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'hCAFEF00D;
        run_one(0, 1'b0, 4'hA, 32'h0, 32'hCAFEF00D, 1'b1, 4);
        slv_err = 1'b0; slv_rdata = 32'h0BADC0DE;
        run_one(1, 1'b0, 4'h7, 32'h0, 32'h0BADC0DE, 1'b0, 4);

        slv_rdata = 32'h5555AAAA;
        rr_burst(2);

        // Leave the pointer at 1, then abort requester 1 mid-ACCESS with reset.
        run_one(0, 1'b1, 4'h1, 32'h11111111, 32'h0, 1'b0, 4);
        slv_stuck = 1'b1;
        @(posedge PCLK); #1;
        raise(1, 1'b0, 4'h6, 32'h0);
        wait_access("reach_access");
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        slv_stuck = 1'b0;
        @(negedge PCLK);
        check("abort_psel", 64'(bus.PSEL), 64'd0);
        check("abort_penable", 64'(bus.PENABLE), 64'd0);
        check("abort_req_done", 64'(req_done), 64'd0);
        repeat (3) @(negedge PCLK);
        rr_burst(1);

        slv_stuck = 1'b1;
`ifdef APB_TIMEOUT_EN
        run_one(0, 1'b0, 4'h4, 32'h0, 32'h0, 1'b1, 19);
`else
        begin
            int n_sel;
            @(posedge PCLK); #1;
            raise(0, 1'b0, 4'h4, 32'h0);
            wait_access("stuck_access");
            n_sel = 0;
            repeat (100) begin
                @(negedge PCLK);
                if (bus.PSEL && bus.PENABLE) n_sel++;
            end
            check("no_timeout_psel", 64'(n_sel), 64'd100);
            @(posedge PCLK); #1;
            PRESET = 1'b1;
            req_valid = '0;
            repeat (2) @(posedge PCLK);
            #1 PRESET = 1'b0;
            @(negedge PCLK);
            check("stuck_reset_psel", 64'(bus.PSEL), 64'd0);
        end
`endif
        slv_stuck = 1'b0;
        repeat (3) @(negedge PCLK);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
